// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of a registered ALU.
// Returns each result with its tag and zero flag over a valid/ready port.
module alu_cmd_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_op,
    input  logic [W-1:0]     alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic [LW-1:0]    fifo_level
);

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, OUT} state_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [TAG_W-1:0] cur_tag;
    state_t           state;
    logic             push;
    logic             pop;
    logic             empty;

    // in_ready ignores a same-cycle pop, so a full FIFO never accepts
    assign empty    = (fifo_level == '0);
    assign in_ready = (fifo_level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (state == IDLE || (state == OUT && out_ready));
    assign head     = mem[rptr];

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wptr] <= {in_a, in_b, in_op, in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            cur_tag   <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
        end else begin
            if (pop) begin
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_op  <= head.op;
                cur_tag <= head.tag;
            end
            unique case (state)
                IDLE: begin
                    if (!empty) state <= EXEC;
                end
                EXEC: begin
                    state <= CAPT;
                end
                CAPT: begin
                    out_y     <= alu_y;
                    out_tag   <= cur_tag;
                    out_zero  <= (alu_y == '0);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= empty ? IDLE : EXEC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: registered ALU stand-in, queue-based
// reference model of the accepted command stream, scenario tasks.
module tb_alu_cmd_sequencer;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int LW    = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [1:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [1:0]       alu_op;
    logic [W-1:0]     alu_y;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic [LW-1:0]    fifo_level;

    typedef struct packed {
        logic [W-1:0]     y;
        logic [TAG_W-1:0] tag;
        logic             zero;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   last_push;

    alu_cmd_sequencer #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // registered ALU the sequencer drives
    always_ff @(posedge clk) begin
        case (alu_op)
            2'b00:   alu_y <= alu_a + alu_b;
            2'b01:   alu_y <= alu_a - alu_b;
            2'b10:   alu_y <= alu_a & alu_b;
            default: alu_y <= alu_a | alu_b;
        endcase
    end

    function automatic res_t model(input int unsigned a, input int unsigned b,
                                   input int unsigned op, input logic [TAG_W-1:0] tag);
        int unsigned r;
        res_t        e;
        case (op)
            0:       r = (a + b) % 65536;
            1:       r = (a + 65536 - b) % 65536;
            2:       r = a & b;
            default: r = a | b;
        endcase
        e.y    = r[W-1:0];
        e.tag  = tag;
        e.zero = (r == 0);
        return e;
    endfunction

    // one clock: records accepted commands and delivered results
    task automatic tick();
        bit   ph;
        bit   oh;
        res_t o;
        res_t m;
        ph = !reset && in_valid && in_ready;
        oh = !reset && out_valid && out_ready;
        o  = '{y: out_y, tag: out_tag, zero: out_zero};
        m  = model(in_a, in_b, in_op, in_tag);
        @(posedge clk);
        #1;
        last_push = ph;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (ph) exp_q.push_back(m);
            if (oh) got_q.push_back(o);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(16'h1111, 16'h2222, 2'b00, 4'h3);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", in_ready);
            else passed++;
            checks++;
            if (fifo_level !== 3'd0) $display("FAIL rst_level got=%0d want=0", fifo_level);
            else passed++;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid);
            else passed++;
            checks++;
            if ({alu_a, alu_b, alu_op} !== '0)
                $display("FAIL rst_alu got=%h/%h/%h want=0", alu_a, alu_b, alu_op);
            else passed++;
            tick();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (fifo_level !== 3'd0 || out_valid !== 1'b0 || got_q.size() != 0)
            $display("FAIL rst_no_accept got level=%0d valid=%b results=%0d want 0/0/0",
                     fifo_level, out_valid, got_q.size());
        else passed++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(16'h0003, 16'h0004, 2'b00, 4'd5);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL single_e0_valid got=%b want=0", out_valid);
        else passed++;
        tick();
        checks++;
        if (alu_a !== 16'h0003 || alu_b !== 16'h0004 || alu_op !== 2'b00)
            $display("FAIL single_issue got=%h/%h/%h want=0003/0004/0", alu_a, alu_b, alu_op);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL single_e2_valid got=%b want=0", out_valid);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_y !== 16'h0007 || out_tag !== 4'd5 || out_zero !== 1'b0)
            $display("FAIL single_e3 got v=%b y=%h tag=%0d z=%b want v=1 y=0007 tag=5 z=0",
                     out_valid, out_y, out_tag, out_zero);
        else passed++;
        tick();
        while (got_q.size() > 0) begin
            res_t g;
            res_t e;
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL single_sb unexpected y=%h tag=%0d", g.y, g.tag);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) $display("FAIL single_sb got=%h want=%h", g, e);
                else passed++;
            end
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        drive(16'h1234, 16'h1234, 2'b01, 4'd1);
        tick();
        drive(16'h0000, 16'h0001, 2'b01, 4'd2);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 50 && got_q.size() < 2; i++) tick();
        checks++;
        if (got_q.size() != 2) begin
            $display("FAIL sub_timeout got=%0d results want=2", got_q.size());
        end else begin
            passed++;
            checks++;
            if (got_q[0].y !== 16'h0000 || got_q[0].zero !== 1'b1 || got_q[0].tag !== 4'd1)
                $display("FAIL sub_zero got y=%h z=%b tag=%0d want 0000/1/1",
                         got_q[0].y, got_q[0].zero, got_q[0].tag);
            else passed++;
            checks++;
            if (got_q[1].y !== 16'hFFFF || got_q[1].zero !== 1'b0 || got_q[1].tag !== 4'd2)
                $display("FAIL sub_wrap got y=%h z=%b tag=%0d want FFFF/0/2",
                         got_q[1].y, got_q[1].zero, got_q[1].tag);
            else passed++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full();
        logic [TAG_W-1:0] first_tag;
        out_ready = 1'b0;
        first_tag = 4'd10;
        for (int i = 0; i < 5; i++) begin
            drive(W'($urandom), W'($urandom), 2'($urandom), TAG_W'(10 + i));
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || fifo_level !== 3'd4)
            $display("FAIL full_level got ready=%b level=%0d want 0/4", in_ready, fifo_level);
        else passed++;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== first_tag)
            $display("FAIL full_hold got v=%b tag=%0d want 1/%0d", out_valid, out_tag, first_tag);
        else passed++;
        drive(W'($urandom), W'($urandom), 2'($urandom), 4'd15);
        out_ready = 1'b1;
        tick();
        checks++;
        if (fifo_level !== 3'd3 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL full_pop_nopush got level=%0d ready=%b v=%b want 3/1/0",
                     fifo_level, in_ready, out_valid);
        else passed++;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4)
            $display("FAIL full_repush got level=%0d want 4", fifo_level);
        else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && got_q.size() < 6; i++) tick();
        checks++;
        if (got_q.size() != 6) $display("FAIL full_timeout got=%0d results want=6", got_q.size());
        else passed++;
        while (got_q.size() > 0) begin
            res_t g;
            res_t e;
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL full_sb unexpected y=%h tag=%0d", g.y, g.tag);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) $display("FAIL full_sb got=%h want=%h", g, e);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_exec();
        bit seen;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(W'($urandom), W'($urandom), 2'($urandom), TAG_W'(i));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (fifo_level !== 3'd2 || out_valid !== 1'b0)
            $display("FAIL rexec_pre got level=%0d v=%b want 2/0", fifo_level, out_valid);
        else passed++;
        while (got_q.size() > 0) begin
            res_t g;
            res_t e;
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rexec_sb unexpected y=%h tag=%0d", g.y, g.tag);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) $display("FAIL rexec_sb got=%h want=%h", g, e);
                else passed++;
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (fifo_level !== 3'd0 || out_valid !== 1'b0 || alu_a !== '0)
            $display("FAIL rexec_reset got level=%0d v=%b a=%h want 0/0/0",
                     fifo_level, out_valid, alu_a);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || got_q.size() != 0)
            $display("FAIL rexec_dropped got valid_seen=%b results=%0d want 0/0",
                     seen, got_q.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int sent;
        logic [W-1:0] a;
        sent = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 30 || got_q.size() < 30); cyc++) begin
            in_valid = 1'b0;
            if (sent < 30) begin
                a = W'($urandom);
                drive(a, ($urandom_range(0, 3) == 0) ? a : W'($urandom),
                      2'($urandom), TAG_W'(sent));
                in_valid = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_push) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got_q.size() != 30) $display("FAIL b2b_timeout got=%0d results want=30", got_q.size());
        else passed++;
        while (got_q.size() > 0) begin
            res_t g;
            res_t e;
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL b2b_sb unexpected y=%h tag=%0d", g.y, g.tag);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) $display("FAIL b2b_sb got=%h want=%h", g, e);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sub();
        test_full();
        test_reset_exec();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
